ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch stage that replaces the combinational simulation memory read.
- Issues one read per instruction on an AXI-Lite-style AR/R channel and presents {pc, inst, fault} to the decode stage over a valid/ready handshake.
- After decode accepts, it waits for the retiring instruction's next PC from the branch unit before fetching again.
- Non-pipelined: at most one instruction in flight.

Parameters:
- RESET_PC, 32'h80000000, address of the first fetch after reset.
- CPU_WIDTH, 32, PC/instruction/data width.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  reset, asynchronous assert, active-high.
- i_next_pc  in  CPU_WIDTH  next PC from the branch unit.
- i_next_pc_vld  in  1  one-cycle strobe: current instruction retired, i_next_pc is valid.
- o_imem_arvalid  out  1  read address valid.
- i_imem_arready  in  1  read address accepted.
- o_imem_araddr  out  CPU_WIDTH  read address (= fetch PC).
- i_imem_rvalid  in  1  read data valid.
- o_imem_rready  out  1  ready to take read data.
- i_imem_rdata  in  CPU_WIDTH  instruction word.
- i_imem_rresp  in  2  response code; 2'b00 = OKAY, anything else = error.
- o_ifu_valid  out  1  fetched instruction valid toward decode.
- i_idu_ready  in  1  decode accepts.
- o_ifu_pc  out  CPU_WIDTH  PC of the presented instruction.
- o_ifu_inst  out  CPU_WIDTH  instruction word.
- o_ifu_fault  out  1  fetch fault (misaligned PC or bus error).

Behaviour:
- FSM states: S_REQ, S_RESP, S_OUT, S_WAITPC. All state flops use async reset.
- Reset values:
  - state = S_REQ; pc_q = RESET_PC.
  - o_imem_arvalid = 1 as soon as reset releases (combinational from state); all other outputs 0.
  - o_ifu_inst = 0, o_ifu_fault = 0.
- S_REQ:
  - arvalid = 1, araddr = pc_q.
  - arvalid and araddr stay stable until arready; no withdrawal.
  - On arready: go to S_RESP.
- S_RESP:
  - rready = 1.
  - On rvalid: latch inst = rdata and fault = (rresp != 0); go to S_OUT.
  - On fault, the latched inst is forced to 0.
  - arready and rvalid in the same cycle while in S_REQ is legal: only the AR transfer is taken that cycle.
- S_OUT:
  - o_ifu_valid = 1, o_ifu_pc = pc_q; pc/inst/fault are held stable until i_idu_ready.
  - On valid&ready: go to S_WAITPC.
- S_WAITPC:
  - On i_next_pc_vld: pc_q <= i_next_pc.
  - If i_next_pc[1:0] == 0: go to S_REQ.
  - Otherwise: no bus request; go directly to S_OUT with fault = 1 and inst = 0.
- i_next_pc_vld outside S_WAITPC is ignored; SIMULATION builds flag it with $error.
- Latency: next_pc_vld to arvalid is 1 cycle. A zero-wait memory gives arvalid → o_ifu_valid in 2 cycles (REQ, RESP, then OUT).
- Reset mid-transaction: the FSM returns to S_REQ at RESET_PC immediately. Any outstanding R beat is not tracked; the memory model must also be reset.
- No PC arithmetic inside this block; PC increment and redirect are owned by the branch unit.

Optional Feature:
- Macro: IFU_FETCH_PERF_EN.
- When defined, the block adds these outputs:
  - o_perf_fetch_cnt [31:0]: +1 per accepted valid&ready toward decode.
  - o_perf_stall_cnt [31:0]: +1 per cycle in S_REQ without arready, or in S_RESP without rvalid.
  - o_perf_fault_cnt [31:0]: +1 per faulted instruction delivered.
- All counters reset to 0 and wrap modulo 2^32.
- When the macro is undefined: these ports and their logic do not exist, and the remaining behaviour is identical.

Decomposition:
- defines.v, shared with the rest of the core, holds:
  - IFU state encodings (2-bit): S_REQ = 2'd0, S_RESP = 2'd1, S_OUT = 2'd2, S_WAITPC = 2'd3.
  - `RESP_OKAY 2'b00.
  - `RESET_PC 32'h80000000 (the parameter default references it).
- One natural sub-module, ifu_fetch_perf, holds the three counters; it is instantiated only under IFU_FETCH_PERF_EN.
- The FSM and data latches stay in ifu_fetch.

Test Plan:
- Reset release, memory with arready = 1 and rvalid one cycle later carrying rdata = 32'h00000413, idu_ready = 1:
  - araddr = 32'h80000000 in the first cycle;
  - o_ifu_valid asserts with pc = 32'h80000000, inst = 32'h00000413, fault = 0.
- Back-pressure: arready low for 3 cycles, then rvalid delayed 4 cycles, then idu_ready low for 2 cycles:
  - arvalid/araddr stable throughout the address stall;
  - o_ifu_valid/pc/inst stable until the handshake;
  - under IFU_FETCH_PERF_EN, stall_cnt = 7.
- Redirect: after the first accept, next_pc_vld with next_pc = 32'h80000010 → next araddr = 32'h80000010 exactly one cycle later.
- Misaligned: next_pc = 32'h80000006 → no arvalid; o_ifu_valid next cycle with fault = 1, inst = 0, pc = 32'h80000006.
- Bus error: rresp = 2'b10 with rdata = 32'hDEADBEEF → o_ifu_fault = 1, o_ifu_inst = 0.
- Async reset asserted in S_RESP mid-transfer → outputs return to reset values without waiting for a clock edge; after release, arvalid = 1 with araddr = 32'h80000000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared IFU definitions: FSM state encodings, bus response code and reset PC.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_RESP   = 2'd1,
        S_OUT    = 2'd2,
        S_WAITPC = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_perf.sv
// IFU performance counters (fetches, stall cycles, faults); used only when
// IFU_FETCH_PERF_EN is defined. Counters wrap modulo 2^32.
module ifu_fetch_perf (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_acc,
    input  logic        i_fault_acc,
    input  logic        i_stall,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_fault_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fault_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_fault_cnt <= '0;
        end else begin
            if (i_fetch_acc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_stall)     r_stall_cnt <= r_stall_cnt + 32'd1;
            if (i_fault_acc) r_fault_cnt <= r_fault_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_fault_cnt = r_fault_cnt;

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one AR/R read per instruction, valid/ready to decode.
// Optional perf counters are enabled by defining IFU_FETCH_PERF_EN.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(RESET_PC_DEF)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CPU_WIDTH-1:0] i_next_pc,
    input  logic                 i_next_pc_vld,
    output logic                 o_imem_arvalid,
    input  logic                 i_imem_arready,
    output logic [CPU_WIDTH-1:0] o_imem_araddr,
    input  logic                 i_imem_rvalid,
    output logic                 o_imem_rready,
    input  logic [CPU_WIDTH-1:0] i_imem_rdata,
    input  logic [1:0]           i_imem_rresp,
    output logic                 o_ifu_valid,
    input  logic                 i_idu_ready,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic [CPU_WIDTH-1:0] o_ifu_inst,
    output logic                 o_ifu_fault
`ifdef IFU_FETCH_PERF_EN
    ,
    output logic [31:0]          o_perf_fetch_cnt,
    output logic [31:0]          o_perf_stall_cnt,
    output logic [31:0]          o_perf_fault_cnt
`endif
);

    ifu_state_e           r_state;
    ifu_state_e           w_next;
    logic [CPU_WIDTH-1:0] r_pc;
    logic [CPU_WIDTH-1:0] r_inst;
    logic                 r_fault;
    logic                 w_rfire;
    logic                 w_rfault;
    logic                 w_redirect;
    logic                 w_misalign;
    logic                 w_acc;

    assign w_rfire    = (r_state == S_RESP) && i_imem_rvalid;
    assign w_rfault   = i_imem_rresp != RESP_OKAY;
    assign w_redirect = (r_state == S_WAITPC) && i_next_pc_vld;
    assign w_misalign = pc_misaligned(i_next_pc[1:0]);
    assign w_acc      = (r_state == S_OUT) && i_idu_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_REQ;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:    if (i_imem_arready) w_next = S_RESP;
            S_RESP:   if (i_imem_rvalid)  w_next = S_OUT;
            S_OUT:    if (i_idu_ready)    w_next = S_WAITPC;
            S_WAITPC: if (i_next_pc_vld)  w_next = w_misalign ? S_OUT : S_REQ;
        endcase
    end

    // A misaligned redirect skips the bus and is delivered directly as a fault.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_fault <= 1'b0;
        end else if (w_rfire) begin
            r_fault <= w_rfault;
            r_inst  <= w_rfault ? '0 : i_imem_rdata;
        end else if (w_redirect) begin
            r_pc <= i_next_pc;
            if (w_misalign) begin
                r_fault <= 1'b1;
                r_inst  <= '0;
            end
        end
    end

    assign o_imem_arvalid = (r_state == S_REQ);
    assign o_imem_araddr  = o_imem_arvalid ? r_pc : '0;
    assign o_imem_rready  = (r_state == S_RESP);
    assign o_ifu_valid    = (r_state == S_OUT);
    assign o_ifu_pc       = o_ifu_valid ? r_pc : '0;
    assign o_ifu_inst     = r_inst;
    assign o_ifu_fault    = r_fault;

`ifdef IFU_FETCH_PERF_EN
    ifu_fetch_perf u_perf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_fetch_acc (w_acc),
        .i_fault_acc (w_acc & r_fault),
        .i_stall     (((r_state == S_REQ) && !i_imem_arready) ||
                      ((r_state == S_RESP) && !i_imem_rvalid)),
        .o_fetch_cnt (o_perf_fetch_cnt),
        .o_stall_cnt (o_perf_stall_cnt),
        .o_fault_cnt (o_perf_fault_cnt)
    );
`else
    logic w_unused_acc;
    assign w_unused_acc = w_acc;
`endif

`ifdef SIMULATION
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_next_pc_vld && r_state != S_WAITPC)
            $error("ifu_fetch: i_next_pc_vld outside S_WAITPC ignored");
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a transaction-level model.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        next_pc_vld;
    logic        arvalid, arready, rvalid, rready, ifu_valid, idu_ready, ifu_fault;
    logic [31:0] araddr, rdata, ifu_pc, ifu_inst;
    logic [1:0]  rresp;
    logic [31:0] perf_fetch, perf_stall, perf_fault;

    always #5 clk = ~clk;

    ifu_fetch #(.CPU_WIDTH(32), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_next_pc(next_pc), .i_next_pc_vld(next_pc_vld),
        .o_imem_arvalid(arvalid), .i_imem_arready(arready), .o_imem_araddr(araddr),
        .i_imem_rvalid(rvalid), .o_imem_rready(rready),
        .i_imem_rdata(rdata), .i_imem_rresp(rresp),
        .o_ifu_valid(ifu_valid), .i_idu_ready(idu_ready),
        .o_ifu_pc(ifu_pc), .o_ifu_inst(ifu_inst), .o_ifu_fault(ifu_fault)
`ifdef IFU_FETCH_PERF_EN
        , .o_perf_fetch_cnt(perf_fetch), .o_perf_stall_cnt(perf_stall),
        .o_perf_fault_cnt(perf_fault)
`endif
    );

`ifndef IFU_FETCH_PERF_EN
    assign perf_fetch = '0;
    assign perf_stall = '0;
    assign perf_fault = '0;
`endif

    // Model: what the fetch stage owes its neighbours, in transaction terms.
    bit          m_addr_pend, m_data_pend, m_deliver, m_need_pc;
    logic [31:0] m_pc, m_inst;
    logic        m_fault;
    int unsigned m_fetch, m_stall, m_faultc;
    int          n_cmp = 0, n_bad = 0;

    logic        s_arvalid, s_valid, s_fault;
    logic [31:0] s_araddr, s_pc, s_inst, s_stall, s_fetch, s_faultc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr_pend = 1; m_data_pend = 0; m_deliver = 0; m_need_pc = 0;
        m_pc = RPC; m_inst = 0; m_fault = 0;
        m_fetch = 0; m_stall = 0; m_faultc = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("arvalid", arvalid, m_addr_pend);
            if (m_addr_pend) chk("araddr", araddr, m_pc);
            chk("rready", rready, m_data_pend);
            chk("ifu_valid", ifu_valid, m_deliver);
            if (m_deliver) begin
                chk("ifu_pc", ifu_pc, m_pc);
                chk("ifu_inst", ifu_inst, m_inst);
                chk("ifu_fault", ifu_fault, m_fault);
            end
`ifdef IFU_FETCH_PERF_EN
            chk("perf_fetch", perf_fetch, m_fetch);
            chk("perf_stall", perf_stall, m_stall);
            chk("perf_fault", perf_fault, m_faultc);
`endif
            s_arvalid = arvalid; s_araddr = araddr; s_valid = ifu_valid;
            s_pc = ifu_pc; s_inst = ifu_inst; s_fault = ifu_fault;
            s_stall = perf_stall; s_fetch = perf_fetch; s_faultc = perf_fault;
            if ((m_addr_pend && !arready) || (m_data_pend && !rvalid)) m_stall++;
            if (m_addr_pend && arready) begin
                m_addr_pend = 0; m_data_pend = 1;
            end else if (m_data_pend && rvalid) begin
                m_data_pend = 0; m_deliver = 1;
                m_fault = (rresp != 2'b00);
                m_inst  = m_fault ? 32'h0 : rdata;
            end else if (m_deliver && idu_ready) begin
                m_deliver = 0; m_need_pc = 1;
                m_fetch++;
                if (m_fault) m_faultc++;
            end else if (m_need_pc && next_pc_vld) begin
                m_need_pc = 0; m_pc = next_pc;
                if (next_pc % 4 == 0) m_addr_pend = 1;
                else begin m_deliver = 1; m_fault = 1; m_inst = 0; end
            end
        end
    end

    // Drive one cycle of environment inputs, let the compare process run, advance.
    task automatic step(input logic ar, input logic rv, input logic [31:0] rd,
                        input logic [1:0] rr, input logic ir, input logic nv,
                        input logic [31:0] np);
        arready = ar; rvalid = rv; rdata = rd; rresp = rr;
        idu_ready = ir; next_pc_vld = nv; next_pc = np;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        idu_ready = 0; next_pc_vld = 0; next_pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rready", rready, 0);
        chk("rst_valid", ifu_valid, 0);
        chk("rst_inst", ifu_inst, 0);
        chk("rst_fault", ifu_fault, 0);
        chk("rst_arvalid", arvalid, 1);
        rst = 0;

        step(1, 0, 0, 0, 1, 0, 0);
        chk("lit_first_arvalid", s_arvalid, 1);
        chk("lit_first_araddr", s_araddr, 32'h8000_0000);
        step(0, 1, 32'h0000_0413, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("lit_first_valid", s_valid, 1);
        chk("lit_first_pc", s_pc, 32'h8000_0000);
        chk("lit_first_inst", s_inst, 32'h0000_0413);
        chk("lit_first_fault", s_fault, 0);
        step(0, 0, 0, 0, 0, 1, 32'h8000_0010);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit_redirect_araddr", s_araddr, 32'h8000_0010);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h1234_5678, 0, 0, 0, 0);
`ifdef IFU_FETCH_PERF_EN
        chk("lit_stall7", s_stall, 32'd7);
`endif
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("lit_bp_inst", s_inst, 32'h1234_5678);
        step(0, 0, 0, 0, 0, 1, 32'h8000_0006);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("lit_mis_arvalid", s_arvalid, 0);
        chk("lit_mis_valid", s_valid, 1);
        chk("lit_mis_fault", s_fault, 1);
        chk("lit_mis_inst", s_inst, 0);
        chk("lit_mis_pc", s_pc, 32'h8000_0006);
        step(0, 0, 0, 0, 0, 1, 32'h8000_0020);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("lit_berr_fault", s_fault, 1);
        chk("lit_berr_inst", s_inst, 0);
`ifdef IFU_FETCH_PERF_EN
        chk("lit_fetch_cnt", s_fetch, 32'd3);
        chk("lit_fault_cnt", s_faultc, 32'd1);
`endif
        step(0, 0, 0, 0, 0, 1, 32'h8000_0040);
        step(1, 0, 0, 0, 0, 0, 0);
        // Now waiting for the R beat: reset asynchronously, mid-cycle.
        rst = 1; arready = 0;
        #1;
        chk("arst_arvalid", arvalid, 1);
        chk("arst_araddr", araddr, 32'h8000_0000);
        chk("arst_rready", rready, 0);
        chk("arst_valid", ifu_valid, 0);
        chk("arst_fault", ifu_fault, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit_arst_arvalid", s_arvalid, 1);
        chk("lit_arst_araddr", s_araddr, 32'h8000_0000);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] np;
            logic        rv;
            np = $urandom();
            if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
            rv = (m_data_pend || m_addr_pend) ? ($urandom_range(0, 2) != 0) : 1'b0;
            step($urandom_range(0, 2) != 0, rv, $urandom(),
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(0, 2) != 0,
                 m_need_pc && ($urandom_range(0, 2) != 0), np);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
